hazard_ctrl: RTL and testbench

- Next-generation pipeline hazard controller for the 5-stage RV32I core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use RAW hazards between the ID-stage and EX-stage instructions. Holds the front end for a parametrised number of bubble cycles using an internal FSM and counter.
- Generates EX-stage operand forwarding selects and flushes on taken branches.
- Keeps a saturating stall-event counter for performance monitoring.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stall FSM,
// EX-stage operand forwarding selects, branch flush and a saturating stall counter.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_ir,
  input  logic [31:0]      ex_ir,
  input  logic [31:0]      mem_ir,
  input  logic [31:0]      wb_ir,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_events
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef logic [REG_ADDR_W-1:0] reg_t;
  typedef enum logic {IDLE, STALL} state_t;

  function automatic reg_t rd_of(input logic [31:0] ir);
    return ir[7 +: REG_ADDR_W];
  endfunction

  function automatic reg_t rs1_of(input logic [31:0] ir);
    return ir[15 +: REG_ADDR_W];
  endfunction

  function automatic reg_t rs2_of(input logic [31:0] ir);
    return ir[20 +: REG_ADDR_W];
  endfunction

  function automatic logic is_load(input logic [31:0] ir);
    return ir[6:0] == OP_LOAD;
  endfunction

  function automatic logic writes_rd(input logic [31:0] ir);
    return (ir != 32'h0) && (ir[6:0] != OP_STORE) && (ir[6:0] != OP_BRANCH)
           && (rd_of(ir) != '0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ir);
    return (ir != 32'h0) && (ir[6:0] != OP_LUI) && (ir[6:0] != OP_AUIPC)
           && (ir[6:0] != OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir != 32'h0)
           && ((ir[6:0] == OP_OP) || (ir[6:0] == OP_STORE) || (ir[6:0] == OP_BRANCH));
  endfunction

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no result yet to forward.
  function automatic logic [1:0] fwd_sel(input logic used, input reg_t src,
                                         input logic [31:0] m_ir, input logic [31:0] w_ir);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != '0)) begin
      if (writes_rd(m_ir) && (rd_of(m_ir) == src) && !is_load(m_ir))
        sel = 2'b10;
      else if (writes_rd(w_ir) && (rd_of(w_ir) == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] events_q, events_d;
  logic             hazard;

  always_comb begin
    hazard = is_load(ex_ir) && writes_rd(ex_ir)
             && ((uses_rs1(id_ir) && (rs1_of(id_ir) == rd_of(ex_ir)))
              || (uses_rs2(id_ir) && (rs2_of(id_ir) == rd_of(ex_ir))));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    events_d = events_q;
    if (branch_taken) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == STALL) begin
      if (cnt_q == 3'd0) state_d = IDLE;
      else               cnt_d   = cnt_q - 3'd1;
    end else if (hazard) begin
      if (events_q != '1) events_d = events_q + CNT_W'(1);
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = 3'(LOAD_STALL_CYCLES - 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      events_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      events_q <= events_d;
    end
  end

  always_comb begin
    stall_if  = !rst && !branch_taken && ((state_q == STALL) || hazard);
    bubble_ex = stall_if;
    flush     = !rst && branch_taken;
    fwd_a     = rst ? 2'b00 : fwd_sel(uses_rs1(ex_ir), rs1_of(ex_ir), mem_ir, wb_ir);
    fwd_b     = rst ? 2'b00 : fwd_sel(uses_rs2(ex_ir), rs2_of(ex_ir), mem_ir, wb_ir);
  end

  assign stall_events = events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1-cycle stall, 3-cycle stall,
// 2-bit counter) share one stimulus stream.
module tb_hazard_ctrl;

  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD  = 32'h00728333;
  localparam logic [31:0] ADD0 = 32'h00000333;
  localparam logic [31:0] SW5  = 32'h00512023;
  localparam logic [31:0] ADI5 = 32'h00100293;
  localparam logic [31:0] ADI7 = 32'h00100393;
  localparam logic [31:0] LUI5 = 32'h000282B7;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] id_ir, ex_ir, mem_ir, wb_ir;
  logic branch_taken;

  logic s1, b1, f1; logic [1:0] fa1, fb1; logic [15:0] e1;
  logic s3, b3, f3; logic [1:0] fa3, fb3; logic [15:0] e3;
  logic sc, bc, fc; logic [1:0] fac, fbc; logic [1:0]  ec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
    .branch_taken(branch_taken), .stall_if(s1), .bubble_ex(b1), .flush(f1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_events(e1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(5), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
    .branch_taken(branch_taken), .stall_if(s3), .bubble_ex(b3), .flush(f3),
    .fwd_a(fa3), .fwd_b(fb3), .stall_events(e3));

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5), .CNT_W(2)) uc (
    .clk(clk), .rst(rst), .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
    .branch_taken(branch_taken), .stall_if(sc), .bubble_ex(bc), .flush(fc),
    .fwd_a(fac), .fwd_b(fbc), .stall_events(ec));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_ir = 32'h0; ex_ir = 32'h0; mem_ir = 32'h0; wb_ir = 32'h0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_ir = LW5; id_ir = ADD; mem_ir = ADI5; wb_ir = ADI7; branch_taken = 1'b1;
    #1;
    checks++; if (s1 !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", s1); end
    checks++; if (f1 !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0b exp=0", f1); end
    checks++; if (fa1 !== 2'b00) begin failures++; $display("FAIL rst_fwd_a got=%0b exp=00", fa1); end
    tick(); tick();
    checks++; if (e1 !== 16'd0) begin failures++; $display("FAIL rst_events got=%0d exp=0", e1); end
    checks++; if (b3 !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%0b exp=0", b3); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_stall_length();
    for (int c = 0; c < 4; c++) begin
      id_ir = ADD;
      ex_ir = (c == 0) ? LW5 : 32'h0;
      #1;
      checks++; if (s1 !== (c == 0)) begin failures++; $display("FAIL len1_stall c=%0d got=%0b exp=%0b", c, s1, (c == 0)); end
      checks++; if (b1 !== (c == 0)) begin failures++; $display("FAIL len1_bubble c=%0d got=%0b exp=%0b", c, b1, (c == 0)); end
      checks++; if (s3 !== (c < 3)) begin failures++; $display("FAIL len3_stall c=%0d got=%0b exp=%0b", c, s3, (c < 3)); end
      tick();
    end
    checks++; if (e1 !== 16'd1) begin failures++; $display("FAIL len1_events got=%0d exp=1", e1); end
    checks++; if (e3 !== 16'd1) begin failures++; $display("FAIL len3_events got=%0d exp=1", e3); end
  endtask

  task automatic test_decode();
    do_reset();
    ex_ir = LW0; id_ir = ADD0;
    #1;
    checks++; if (s1 !== 1'b0) begin failures++; $display("FAIL lw_x0_stall got=%0b exp=0", s1); end
    ex_ir = LW5; id_ir = SW5;
    #1;
    checks++; if (s1 !== 1'b1) begin failures++; $display("FAIL sw_rs2_stall got=%0b exp=1", s1); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL sw_rs2_bubble got=%0b exp=1", b1); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    do_reset();
    ex_ir = ADD; mem_ir = ADI5; wb_ir = ADI7;
    #1;
    checks++; if (fa1 !== 2'b10) begin failures++; $display("FAIL fwd_a_mem got=%0b exp=10", fa1); end
    checks++; if (fb1 !== 2'b01) begin failures++; $display("FAIL fwd_b_wb got=%0b exp=01", fb1); end
    mem_ir = LW5;
    #1;
    checks++; if (fa1 !== 2'b00) begin failures++; $display("FAIL fwd_a_load got=%0b exp=00", fa1); end
    mem_ir = ADI5; wb_ir = ADI5;
    #1;
    checks++; if (fa1 !== 2'b10) begin failures++; $display("FAIL fwd_a_prio got=%0b exp=10", fa1); end
    checks++; if (fb1 !== 2'b00) begin failures++; $display("FAIL fwd_b_none got=%0b exp=00", fb1); end
    mem_ir = LW5;
    #1;
    checks++; if (fa1 !== 2'b01) begin failures++; $display("FAIL fwd_a_wb_behind_load got=%0b exp=01", fa1); end
    ex_ir = LUI5; mem_ir = ADI5;
    #1;
    checks++; if (fa1 !== 2'b00) begin failures++; $display("FAIL fwd_a_lui got=%0b exp=00", fa1); end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_ir = LW5; id_ir = ADD;
    #1;
    checks++; if (s3 !== 1'b1) begin failures++; $display("FAIL br_pre_stall got=%0b exp=1", s3); end
    tick();
    ex_ir = 32'h0; branch_taken = 1'b1;
    #1;
    checks++; if (f3 !== 1'b1) begin failures++; $display("FAIL br_flush got=%0b exp=1", f3); end
    checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL br_stall got=%0b exp=0", s3); end
    checks++; if (b3 !== 1'b0) begin failures++; $display("FAIL br_bubble got=%0b exp=0", b3); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL br_idle_after got=%0b exp=0", s3); end
    checks++; if (e3 !== 16'd1) begin failures++; $display("FAIL br_events3 got=%0d exp=1", e3); end
    ex_ir = LW5; branch_taken = 1'b1;
    #1;
    checks++; if (s1 !== 1'b0) begin failures++; $display("FAIL br_haz_stall got=%0b exp=0", s1); end
    tick();
    clear_inputs();
    #1;
    checks++; if (e1 !== 16'd1) begin failures++; $display("FAIL br_haz_events got=%0d exp=1", e1); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ex_ir = LW5; id_ir = ADD;
    tick();
    ex_ir = 32'h0;
    #1;
    checks++; if (s3 !== 1'b1) begin failures++; $display("FAIL mid_in_stall got=%0b exp=1", s3); end
    rst = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%0b exp=0", s3); end
    checks++; if (f3 !== 1'b0) begin failures++; $display("FAIL mid_rst_flush got=%0b exp=0", f3); end
    tick();
    rst = 1'b0; branch_taken = 1'b0;
    #1;
    checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL mid_after_stall got=%0b exp=0", s3); end
    checks++; if (e3 !== 16'd0) begin failures++; $display("FAIL mid_after_events got=%0d exp=0", e3); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_ir = LW5; id_ir = ADD;
    tick(); tick(); tick();
    checks++; if (ec !== 2'b11) begin failures++; $display("FAIL sat_reach got=%0b exp=11", ec); end
    tick();
    checks++; if (ec !== 2'b11) begin failures++; $display("FAIL sat_hold got=%0b exp=11", ec); end
    checks++; if (e1 !== 16'd4) begin failures++; $display("FAIL b2b_events1 got=%0d exp=4", e1); end
    checks++; if (e3 !== 16'd2) begin failures++; $display("FAIL b2b_events3 got=%0d exp=2", e3); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_stall_length();
    test_decode();
    test_forwarding();
    test_branch();
    test_reset_mid_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
